// File: rtl/seq_pattern_detector.sv
// -----------------------------------------------------------------------------
// seq_pattern_detector
//   Serial bit-pattern detector with a registered Moore match flag. A PAT_W-bit
//   history shift register (newest bit at the LSB) is compared against a
//   runtime-loadable pattern register. A fill counter ensures that a match
//   needs PAT_W accepted bits since reset or since the last flush. Each new
//   match increments a saturating counter.
//
//   Optional build macro: SEQDET_MASK_EN
//     When it is defined, the block gets a `mask` input that is loaded with
//     pat_load. A mask bit of 0 makes that pattern position don't-care.
//
// Parameters
//   PAT_W   pattern length in bits (2..16)
//   PAT_RST pattern register value after reset (MSB = oldest bit)
//   CNT_W   match counter width
//
// Ports
//   clk         rising-edge clock
//   areset_n    asynchronous active-low reset
//   in_valid    qualifies `in`
//   in          serial data bit
//   overlap     1 = overlapping matches; 0 = restart window after a match
//   pat_load    load `pattern` (and `mask`) and flush the history
//   pattern     new pattern value
//   mask        (SEQDET_MASK_EN only) compare mask, 1 = bit must match
//   cnt_clr     synchronous clear of match_count
//   out         registered match flag
//   match_count saturating match counter
//   cnt_sat     match_count is all ones
// -----------------------------------------------------------------------------
module seq_pattern_detector #(
  parameter int               PAT_W   = 3,
  parameter logic [PAT_W-1:0] PAT_RST = 3'b101,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             in_valid,
  input  logic             in,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pattern,
`ifdef SEQDET_MASK_EN
  input  logic [PAT_W-1:0] mask,
`endif
  input  logic             cnt_clr,
  output logic             out,
  output logic [CNT_W-1:0] match_count,
  output logic             cnt_sat
);

  localparam int               FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [PAT_W-1:0]  pat_q,  pat_d;
  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              out_q,  out_d;
  logic [CNT_W-1:0]  cnt_q,  cnt_d;
  logic              sat_q,  sat_d;
  logic              accept;
  logic              hit;

`ifdef SEQDET_MASK_EN
  logic [PAT_W-1:0]  mask_q, mask_d;
`endif

  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    accept = 1'b0;
`ifdef SEQDET_MASK_EN
    mask_d = mask_q;
`endif

    if (pat_load) begin
      // Loading takes priority; any bit offered this cycle is dropped.
      pat_d  = pattern;
      hist_d = '0;
      fill_d = '0;
`ifdef SEQDET_MASK_EN
      mask_d = mask;
`endif
    end else if (in_valid) begin
      accept = 1'b1;
      hist_d = {hist_q[PAT_W-2:0], in};
      if (!overlap && out_q) begin
        // Non-overlapping: the bits of the previous match are not reused,
        // so the incoming bit is the first of a fresh window.
        fill_d = FILL_W'(1);
      end else if (fill_q != FILL_FULL) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end

    // The flag is evaluated on next-state values so that it is high in the
    // cycle right after the completing bit and is purely registered.
`ifdef SEQDET_MASK_EN
    hit = ((hist_d ^ pat_d) & mask_d) == '0;
`else
    hit = (hist_d == pat_d);
`endif
    out_d = (fill_d == FILL_FULL) && hit;

    // Only a freshly accepted bit may count; a held flag does not re-count.
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (accept && out_d && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
    sat_d = (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      pat_q  <= PAT_RST;
      hist_q <= '0;
      fill_q <= '0;
      out_q  <= 1'b0;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
      sat_q  <= sat_d;
    end
  end

`ifdef SEQDET_MASK_EN
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      mask_q <= '1;
    end else begin
      mask_q <= mask_d;
    end
  end
`endif

  assign out         = out_q;
  assign match_count = cnt_q;
  assign cnt_sat     = sat_q;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// -----------------------------------------------------------------------------
// tb_seq_pattern_detector
//   Table-driven bench for seq_pattern_detector (PAT_W=3, CNT_W=2). Each table
//   row holds the inputs for one clock plus the expected registered outputs
//   after that edge. Expected values go into a scoreboard queue when the row
//   is driven and are popped and compared after the clock edge. A hand-written
//   sequence then covers asynchronous reset in the middle of a stream.
// -----------------------------------------------------------------------------
module tb_seq_pattern_detector;

  localparam int PAT_W = 3;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             areset_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_bit = 1'b0;
  logic             overlap = 1'b1;
  logic             pat_load = 1'b0;
  logic [PAT_W-1:0] pattern = '0;
  logic             cnt_clr = 1'b0;
  logic             out;
  logic [CNT_W-1:0] match_count;
  logic             cnt_sat;
`ifdef SEQDET_MASK_EN
  logic [PAT_W-1:0] mask = '1;
`endif

  seq_pattern_detector #(
    .PAT_W  (PAT_W),
    .PAT_RST(3'b101),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .areset_n   (areset_n),
    .in_valid   (in_valid),
    .in         (in_bit),
    .overlap    (overlap),
    .pat_load   (pat_load),
    .pattern    (pattern),
`ifdef SEQDET_MASK_EN
    .mask       (mask),
`endif
    .cnt_clr    (cnt_clr),
    .out        (out),
    .match_count(match_count),
    .cnt_sat    (cnt_sat)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic       b;
    logic       ov;
    logic       pl;
    logic [2:0] pat;
    logic       clr;
    logic       e_out;
    logic [1:0] e_cnt;
    logic       e_sat;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] exp_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  function automatic void add(input int v, input int b, input int ov, input int pl,
                              input int pat, input int clr,
                              input int e_out, input int e_cnt, input int e_sat);
    vec_t t;
    t.v     = v[0];
    t.b     = b[0];
    t.ov    = ov[0];
    t.pl    = pl[0];
    t.pat   = pat[2:0];
    t.clr   = clr[0];
    t.e_out = e_out[0];
    t.e_cnt = e_cnt[1:0];
    t.e_sat = e_sat[0];
    vecs.push_back(t);
  endfunction

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got out/cnt/sat=%b/%0d/%b, expected %b/%0d/%b",
               name, got[3], got[2:1], got[0], exp[3], exp[2:1], exp[0]);
    end else begin
      $display("[TB] ok   %s: out/cnt/sat=%b/%0d/%b", name, got[3], got[2:1], got[0]);
    end
  endtask

  // Drive one row at the falling edge, score it after the next rising edge.
  task automatic step(input vec_t t, input string name);
    in_valid = t.v;
    in_bit   = t.b;
    overlap  = t.ov;
    pat_load = t.pl;
    pattern  = t.pat;
    cnt_clr  = t.clr;
    exp_q.push_back({t.e_out, t.e_cnt, t.e_sat});
    @(posedge clk);
    #1;
    check(name, {out, match_count, cnt_sat}, exp_q.pop_front());
    @(negedge clk);
  endtask

  task automatic bit_in(input int b, input int e_out, input int e_cnt, input string name);
    vec_t t;
    t = '0;
    t.v     = 1'b1;
    t.b     = b[0];
    t.ov    = 1'b1;
    t.e_out = e_out[0];
    t.e_cnt = e_cnt[1:0];
    step(t, name);
  endtask

  initial begin
    // --- reset state ---
    #12;
    check("reset_state", {out, match_count, cnt_sat}, 4'b0000);
    @(negedge clk);
    areset_n = 1'b1;
    @(negedge clk);

    // Test 1: overlap=1, default pattern 101, bits 1,0,1,0,1
    add(1,1,1,0,0,0, 0,0,0);
    add(1,0,1,0,0,0, 0,0,0);
    add(1,1,1,0,0,0, 1,1,0);
    add(1,0,1,0,0,0, 0,1,0);
    add(1,1,1,0,0,0, 1,2,0);
    add(0,0,1,0,0,1, 1,0,0);   // clear while idle; flag holds
    // Test 2: flush, then same stream with overlap=0
    add(0,0,0,1,5,0, 0,0,0);
    add(1,1,0,0,0,0, 0,0,0);
    add(1,0,0,0,0,0, 0,0,0);
    add(1,1,0,0,0,0, 1,1,0);
    add(1,0,0,0,0,0, 0,1,0);
    add(1,1,0,0,0,0, 0,1,0);   // window restarted: no reuse of matched bits
    add(0,0,1,0,0,1, 0,0,0);
    // Test 3: 1,0, valid gap of 4 (bits offered are ignored), then 1
    add(0,0,1,1,5,0, 0,0,0);
    add(1,1,1,0,0,0, 0,0,0);
    add(1,0,1,0,0,0, 0,0,0);
    add(0,0,1,0,0,0, 0,0,0);
    add(0,0,1,0,0,0, 0,0,0);
    add(0,1,1,0,0,0, 0,0,0);
    add(0,1,1,0,0,0, 0,0,0);
    add(1,1,1,0,0,0, 1,1,0);
    add(0,1,1,0,0,0, 1,1,0);   // held flag, no recount
    add(0,0,1,0,0,0, 1,1,0);
    // Test 4: 1,1, pat_load 110 with a dropped 0, then 1,1,0
    add(1,1,1,0,0,0, 0,1,0);
    add(1,1,1,0,0,0, 0,1,0);
    add(1,0,1,1,6,0, 0,1,0);
    add(1,1,1,0,0,0, 0,1,0);
    add(1,1,1,0,0,0, 0,1,0);
    add(1,0,1,0,0,0, 1,2,0);
    // Test 5: saturation with a 2-bit counter, clear coincident with 5th match
    add(0,0,1,0,0,1, 1,0,0);
    for (int m = 1; m <= 5; m++) begin
      add(1,1,1,0,0,0, 0,(m > 3) ? 3 : m - 1,(m > 3) ? 1 : 0);
      add(1,1,1,0,0,0, 0,(m > 3) ? 3 : m - 1,(m > 3) ? 1 : 0);
      if (m < 5) add(1,0,1,0,0,0, 1,(m > 3) ? 3 : m,(m >= 3) ? 1 : 0);
      else       add(1,0,1,0,0,1, 1,0,0);
    end

    foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));

    // Test 6: async reset mid-sequence (pattern currently 110)
    bit_in(1, 0, 0, "pre_rst_b1");   // hist 101
    bit_in(0, 0, 0, "pre_rst_b0");   // hist 010
    #2 areset_n = 1'b0;
    #1;
    check("async_reset", {out, match_count, cnt_sat}, 4'b0000);
    @(negedge clk);
    areset_n = 1'b1;
    @(negedge clk);
    // Stale history 010 plus this 1 would read 101; fill must block it.
    bit_in(1, 0, 0, "post_rst_b1");
    bit_in(0, 0, 0, "post_rst_b0");
    bit_in(1, 1, 1, "post_rst_match");

    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
